// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream instruction handshake in, decoded ALU operands
// and side-band control out. The stage itself connects through the slave
// modport; whatever feeds it and consumes its result uses master.
interface alu_issue_if;
  // Upstream handshake and instruction payload
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;

  // Downstream handshake and decoded result
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_control_code;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        is_branch;
  logic        is_jump;
  logic        illegal;
  logic [2:0]  branch_funct3;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, operand_a, operand_b, alu_control_code,
    input  imm, rd, reg_write, mem_read, mem_write, is_branch, is_jump,
    input  illegal, branch_funct3
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, operand_a, operand_b, alu_control_code,
    output imm, rd, reg_write, mem_read, mem_write, is_branch, is_jump,
    output illegal, branch_funct3
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode-to-execute issue register. Decodes the incoming instruction
// combinationally into ALU operands, ALU operation code and side-band
// control, then holds the result in a single-entry valid/ready pipeline
// register with flush. Full throughput: a held instruction can be consumed
// and replaced on the same edge.
module alu_issue_stage (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus
);

  // RV32I major opcodes handled by this stage
  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011
  } opcode_e;

  // ALU operation codes; OP-type codes are {funct7[5], funct3}
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  // Everything the issue register carries to the execute stage
  typedef struct packed {
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] imm;
    alu_op_e     alu_control_code;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
    logic [2:0]  branch_funct3;
  } issue_t;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // Instruction fields
  opcode_e     opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  logic [4:0]  shamt;

  // Sign-extended immediates for every format
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;

  assign opcode   = opcode_e'(bus.instr[6:0]);
  assign funct3   = bus.instr[14:12];
  assign funct7   = bus.instr[31:25];
  assign rd_field = bus.instr[11:7];
  assign shamt    = bus.instr[24:20];

  assign i_imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign s_imm = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign b_imm = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                  bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign u_imm = {bus.instr[31:12], 12'b0};
  assign j_imm = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                  bus.instr[20], bus.instr[30:21], 1'b0};

  // Decode result, handshake state and the issue register itself
  issue_t dec;
  issue_t held;
  logic   legal;
  logic   writes_rd;
  logic   out_valid_q;
  logic   load;

  // Combinational decode of the offered instruction into an issue_t
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    dec               = '0;
    dec.rd            = rd_field;
    dec.branch_funct3 = funct3;
    legal             = 1'b1;
    writes_rd         = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec.operand_a        = bus.rs1_data;
        dec.operand_b        = bus.rs2_data;
        dec.alu_control_code = alu_op_e'({funct7[5], funct3});
        writes_rd            = 1'b1;
        // SUB and SRA are the only alternate-funct7 encodings
        if (!((funct7 == FUNCT7_ZERO) ||
              ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
          legal = 1'b0;
      end

      OPC_OP_IMM: begin
        dec.operand_a        = bus.rs1_data;
        dec.operand_b        = i_imm;
        dec.imm              = i_imm;
        dec.alu_control_code = alu_op_e'({1'b0, funct3});
        writes_rd            = 1'b1;
        if (funct3 == 3'b001) begin
          dec.operand_b = {27'b0, shamt};
          if (funct7 != FUNCT7_ZERO)
            legal = 1'b0;
        end else if (funct3 == 3'b101) begin
          // SRLI vs SRAI is chosen by funct7[5]
          dec.operand_b        = {27'b0, shamt};
          dec.alu_control_code = alu_op_e'({funct7[5], 3'b101});
          if ((funct7 != FUNCT7_ZERO) && (funct7 != FUNCT7_ALT))
            legal = 1'b0;
        end
      end

      OPC_LUI: begin
        dec.operand_b = u_imm;
        dec.imm       = u_imm;
        writes_rd     = 1'b1;
      end

      OPC_AUIPC: begin
        dec.operand_a = bus.pc;
        dec.operand_b = u_imm;
        dec.imm       = u_imm;
        writes_rd     = 1'b1;
      end

      OPC_JAL: begin
        // ALU computes the link value pc+4; target uses imm
        dec.operand_a = bus.pc;
        dec.operand_b = 32'd4;
        dec.imm       = j_imm;
        dec.is_jump   = 1'b1;
        writes_rd     = 1'b1;
      end

      OPC_JALR: begin
        dec.operand_a = bus.pc;
        dec.operand_b = 32'd4;
        dec.imm       = i_imm;
        dec.is_jump   = 1'b1;
        writes_rd     = 1'b1;
        if (funct3 != 3'b000)
          legal = 1'b0;
      end

      OPC_BRANCH: begin
        dec.operand_a = bus.rs1_data;
        dec.operand_b = bus.rs2_data;
        dec.imm       = b_imm;
        dec.is_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec.alu_control_code = ALU_SUB;
          3'b100, 3'b101: dec.alu_control_code = ALU_SLT;
          3'b110, 3'b111: dec.alu_control_code = ALU_SLTU;
          default:        legal = 1'b0;
        endcase
      end

      OPC_LOAD: begin
        dec.operand_a = bus.rs1_data;
        dec.operand_b = i_imm;
        dec.imm       = i_imm;
        dec.mem_read  = 1'b1;
        writes_rd     = 1'b1;
      end

      OPC_STORE: begin
        dec.operand_a = bus.rs1_data;
        dec.operand_b = s_imm;
        dec.imm       = s_imm;
        dec.mem_write = 1'b1;
      end

      default: legal = 1'b0;
    endcase

    dec.reg_write = writes_rd && (rd_field != 5'd0);

    // Illegal instructions still flow to the trap logic, but with no
    // side effects and neutral ALU inputs.
    if (!legal) begin
      dec.operand_a        = '0;
      dec.operand_b        = '0;
      dec.imm              = '0;
      dec.alu_control_code = ALU_ADD;
      dec.reg_write        = 1'b0;
      dec.mem_read         = 1'b0;
      dec.mem_write        = 1'b0;
      dec.is_branch        = 1'b0;
      dec.is_jump          = 1'b0;
      dec.illegal          = 1'b1;
    end
  end

  // Accept when empty or when the held instruction leaves this cycle
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready && !bus.flush;

  // Issue register: flush beats load, load beats consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload is reset too (not just out_valid) so every output
      // reads as zero out of reset; it is a single entry, not a memory.
      out_valid_q <= 1'b0;
      held        <= '0;
    end else if (bus.flush) begin
      // Payload may keep stale data; consumers qualify with out_valid
      out_valid_q <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking so valid and payload update together at the edge.
      out_valid_q <= 1'b1;
      held        <= dec;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.operand_a        = held.operand_a;
  assign bus.operand_b        = held.operand_b;
  assign bus.alu_control_code = held.alu_control_code;
  assign bus.imm              = held.imm;
  assign bus.rd               = held.rd;
  assign bus.reg_write        = held.reg_write;
  assign bus.mem_read         = held.mem_read;
  assign bus.mem_write        = held.mem_write;
  assign bus.is_branch        = held.is_branch;
  assign bus.is_jump          = held.is_jump;
  assign bus.illegal          = held.illegal;
  assign bus.branch_funct3    = held.branch_funct3;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. Expected decode results are written
// out by hand per instruction, pushed to a scoreboard when the stage accepts
// the instruction, and compared when the stage hands the result on.
module tb_alu_issue_stage;

  // Flag vector order: {reg_write, mem_read, mem_write, is_branch, is_jump, illegal}
  localparam logic [5:0] F_WB  = 6'b100000;
  localparam logic [5:0] F_MR  = 6'b010000;
  localparam logic [5:0] F_MW  = 6'b001000;
  localparam logic [5:0] F_BR  = 6'b000100;
  localparam logic [5:0] F_JMP = 6'b000010;
  localparam logic [5:0] F_ILL = 6'b000001;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  code;
    logic [5:0]  flags;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  bf3;
    bit          chk_imm;
    bit          chk_rd;
    bit          chk_bf3;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   n_pop;
  exp_t cur_exp;
  exp_t sb[$];

  alu_issue_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] code, input logic [5:0] flags);
    exp_t e;
    e.a = a; e.b = b; e.code = code; e.flags = flags;
    e.imm = '0; e.rd = '0; e.bf3 = '0;
    e.chk_imm = 1'b0; e.chk_rd = 1'b0; e.chk_bf3 = 1'b0;
    return e;
  endfunction

  function automatic exp_t with_rd(input exp_t e, input logic [4:0] rd);
    exp_t r = e;
    r.rd = rd; r.chk_rd = 1'b1;
    return r;
  endfunction

  function automatic exp_t with_imm(input exp_t e, input logic [31:0] imm);
    exp_t r = e;
    r.imm = imm; r.chk_imm = 1'b1;
    return r;
  endfunction

  function automatic exp_t with_bf3(input exp_t e, input logic [2:0] bf3);
    exp_t r = e;
    r.bf3 = bf3; r.chk_bf3 = 1'b1;
    return r;
  endfunction

  task automatic compare_out(input exp_t e, input int idx);
    check($sformatf("op%0d.operand_a", idx), bus.operand_a, e.a);
    check($sformatf("op%0d.operand_b", idx), bus.operand_b, e.b);
    check($sformatf("op%0d.alu_code", idx), {28'b0, bus.alu_control_code}, {28'b0, e.code});
    check($sformatf("op%0d.flags", idx),
          {26'b0, bus.reg_write, bus.mem_read, bus.mem_write,
           bus.is_branch, bus.is_jump, bus.illegal}, {26'b0, e.flags});
    if (e.chk_imm) check($sformatf("op%0d.imm", idx), bus.imm, e.imm);
    if (e.chk_rd)  check($sformatf("op%0d.rd", idx), {27'b0, bus.rd}, {27'b0, e.rd});
    if (e.chk_bf3) check($sformatf("op%0d.branch_funct3", idx),
                         {29'b0, bus.branch_funct3}, {29'b0, e.bf3});
  endtask

  // Scoreboard push on accept; drop the held entry on flush
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.flush && bus.out_valid && (sb.size() > 0))
        void'(sb.pop_front());
      if (bus.in_valid && bus.in_ready && !bus.flush)
        sb.push_back(cur_exp);
    end
  end

  // Scoreboard pop and compare on each consume
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        check("spurious_output", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        compare_out(e, n_pop);
        n_pop++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
    bus.in_valid = 1'b1;
    bus.instr    = instr;
    bus.pc       = pc;
    bus.rs1_data = rs1;
    bus.rs2_data = rs2;
    cur_exp      = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; n_pop = 0;
    cur_exp = mk('0, '0, '0, '0);
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst.operand_a", bus.operand_a, 32'd0);
    check("rst.operand_b", bus.operand_b, 32'd0);
    check("rst.imm", bus.imm, 32'd0);
    check("rst.ctrl", {20'b0, bus.alu_control_code, bus.rd, bus.branch_funct3},
          32'd0);
    check("rst.flags", {26'b0, bus.reg_write, bus.mem_read, bus.mem_write,
                        bus.is_branch, bus.is_jump, bus.illegal}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst.out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Back-to-back stream at full throughput
    bus.out_ready = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7, with_rd(mk(32'd5, 32'd7, 4'b0000, F_WB), 5'd3));
    step();
    check("load_latency.out_valid", {31'b0, bus.out_valid}, 32'd1);
    drive(32'h402081B3, 32'h0, 32'd5, 32'd7, with_rd(mk(32'd5, 32'd7, 4'b1000, F_WB), 5'd3));
    step();
    drive(32'h40315093, 32'h0, 32'h80000000, 32'h0,
          with_rd(mk(32'h80000000, 32'd3, 4'b1101, F_WB), 5'd1));
    step();
    drive(32'h0020C463, 32'h0, 32'h11, 32'h22,
          with_bf3(with_imm(mk(32'h11, 32'h22, 4'b0010, F_BR), 32'd8), 3'b100));
    step();
    drive(32'h0020F463, 32'h0, 32'h11, 32'h22,
          with_bf3(with_imm(mk(32'h11, 32'h22, 4'b0011, F_BR), 32'd8), 3'b111));
    step();
    drive(32'hFE208EE3, 32'h0, 32'h33, 32'h44,
          with_bf3(with_imm(mk(32'h33, 32'h44, 4'b1000, F_BR), 32'hFFFFFFFC), 3'b000));
    step();
    drive(32'h12345297, 32'h1000, 32'h55, 32'h66,
          with_rd(mk(32'h1000, 32'h12345000, 4'b0000, F_WB), 5'd5));
    step();
    drive(32'h010000EF, 32'h2000, 32'h55, 32'h66,
          with_rd(with_imm(mk(32'h2000, 32'd4, 4'b0000, F_WB | F_JMP), 32'd16), 5'd1));
    step();
    drive(32'h000010E7, 32'h3000, 32'h55, 32'h66, mk(32'h0, 32'h0, 4'b0000, F_ILL));
    step();
    drive(32'h00000000, 32'h3004, 32'h99, 32'h77, mk(32'h0, 32'h0, 4'b0000, F_ILL));
    step();
    drive(32'hFFC0A303, 32'h0, 32'h100, 32'h0,
          with_rd(mk(32'h100, 32'hFFFFFFFC, 4'b0000, F_WB | F_MR), 5'd6));
    step();
    drive(32'h0020A423, 32'h0, 32'h200, 32'hDEAD,
          with_imm(mk(32'h200, 32'd8, 4'b0000, F_MW), 32'd8));
    step();
    drive(32'h00208033, 32'h0, 32'd1, 32'd2, with_rd(mk(32'd1, 32'd2, 4'b0000, 6'b0), 5'd0));
    step();
    drive(32'h022081B3, 32'h0, 32'd1, 32'd2, mk(32'h0, 32'h0, 4'b0000, F_ILL));
    step();
    drive(32'hABCDE3B7, 32'h0, 32'h12, 32'h34,
          with_rd(mk(32'h0, 32'hABCDE000, 4'b0000, F_WB), 5'd7));
    step();
    bus.in_valid = 1'b0;
    step();
    check("drain.out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Backpressure: hold A for three cycles while B waits upstream
    bus.out_ready = 1'b0;
    drive(32'hABCDE3B7, 32'h0, 32'h0, 32'h0,
          with_rd(mk(32'h0, 32'hABCDE000, 4'b0000, F_WB), 5'd7));
    step();
    drive(32'h0020A423, 32'h0, 32'h400, 32'h1,
          with_imm(mk(32'h400, 32'd8, 4'b0000, F_MW), 32'd8));
    repeat (3) begin
      @(negedge clk);
      check("stall.in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("stall.out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("stall.operand_b", bus.operand_b, sb[0].b);
      check("stall.reg_write", {31'b0, bus.reg_write}, {31'b0, sb[0].flags[5]});
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();

    // Flush with an instruction held and another offered
    bus.out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd8, 32'd9, mk(32'd8, 32'd9, 4'b0000, F_WB));
    step();
    drive(32'hFE208EE3, 32'h0, 32'h1, 32'h2, mk(32'h1, 32'h2, 4'b1000, F_BR));
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("pre_flush.out_valid", {31'b0, bus.out_valid}, 32'd1);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush.out_valid", {31'b0, bus.out_valid}, 32'd0);
    step();
    drive(32'hFFC0A303, 32'h0, 32'h300, 32'h0,
          with_rd(mk(32'h300, 32'hFFFFFFFC, 4'b0000, F_WB | F_MR), 5'd6));
    step();
    bus.in_valid = 1'b0;
    step();

    // Reset asserted while stalled drops the held instruction at once
    bus.out_ready = 1'b0;
    drive(32'hABCDE3B7, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'hABCDE000, 4'b0000, F_WB));
    step();
    drive(32'h402081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'b1000, F_WB));
    step();
    check("stall2.out_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst.in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("midrst.operand_b", bus.operand_b, 32'd0);
    sb.delete();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    drive(32'h002081B3, 32'h0, 32'd9, 32'd1, with_rd(mk(32'd9, 32'd1, 4'b0000, F_WB), 5'd3));
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();

    check("consumed_count", n_pop, 32'd19);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue register for the RV32I pipeline. Takes a fetched instruction with its PC and register-file read data, and produces the ALU's `operand_a`, `operand_b` and 4-bit `alu_control_code`, plus side-band control for branch, memory and writeback. The result is held in a single-entry pipeline register with valid/ready flow control and flush.

## Interface

No parameters; the datapath is fixed at 32 bits.

- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous active-low reset
- `in_valid` in 1: upstream instruction valid
- `in_ready` out 1: stage can accept an instruction this cycle
- `instr` in 32: RV32I instruction word
- `pc` in 32: PC of `instr`
- `rs1_data`, `rs2_data` in 32: register-file read data
- `flush` in 1: discard the held and incoming instruction
- `out_valid` out 1: issue register holds an instruction
- `out_ready` in 1: execute stage consumes the held instruction
- `operand_a`, `operand_b` out 32: ALU operands
- `alu_control_code` out 4: ALU operation code
- `imm` out 32: decoded sign-extended immediate
- `rd` out 5: destination register
- `reg_write`, `mem_read`, `mem_write`, `is_branch`, `is_jump`, `illegal` out 1: control flags
- `branch_funct3` out 3: `instr[14:12]` for branch condition selection

## Operation

- ALU codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
- **OP (0110011):**
  - a=rs1, b=rs2, code={funct7[5], funct3}.
  - funct7 must be 0000000, or 0100000 with funct3 ∈ {000, 101}; any other funct7 is illegal.
- **OP-IMM (0010011):**
  - a=rs1, b=I-imm, code={0, funct3}.
  - Shifts (funct3 001/101): b={27'b0, instr[24:20]}. funct3=101 gives code {funct7[5], 101}. funct7 must be 0000000; 0100000 is also allowed for 101. Any other funct7 is illegal.
- **LUI:** a=0, b=U-imm, ADD.
- **AUIPC:** a=pc, b=U-imm, ADD.
- **JAL / JALR:**
  - a=pc, b=32'd4, ADD (link value); is_jump=1; imm = J-imm / I-imm.
  - JALR requires funct3=000, otherwise illegal.
- **BRANCH (1100011):**
  - a=rs1, b=rs2, is_branch=1, imm=B-imm.
  - funct3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; 010/011 → illegal.
- **LOAD:** a=rs1, b=I-imm, ADD, mem_read=1.
- **STORE:** a=rs1, b=S-imm, ADD, mem_write=1, imm=S-imm.
- reg_write=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, only when rd≠0.
- `illegal` cases (including unknown opcodes):
  - illegal=1; code=ADD; operands=0.
  - reg_write, mem_read, mem_write, is_branch, is_jump all 0.
  - The instruction still flows through the handshake so the trap logic sees it.
- Decode is combinational on `instr`; all outputs except `in_ready` are registered.

## Timing

- Reset (async assert, sync release): out_valid=0 and every registered output is 0. in_ready=1 while in reset.
- in_ready = !out_valid || out_ready (combinational).
- **Load:** when in_valid && in_ready && !flush, the decoded instruction is captured at the clock edge and out_valid=1. Latency is 1 cycle.
- **Consume:** out_valid && out_ready with no new load → out_valid=0 next cycle.
- **Simultaneous consume and load:** the register is replaced with the new instruction; out_valid stays 1. No bubble, so full throughput is 1 instruction per cycle.
- **Stall:** out_valid && !out_ready → all outputs hold stable and in_ready=0.
- **Flush has priority:**
  - out_valid=0 next cycle and any instruction offered that cycle is dropped.
  - Data outputs may keep stale values; consumers qualify them with out_valid.
- Reset mid-stall: the held instruction is lost and out_valid goes to 0 immediately.

## Test plan

- **ADD, then SUB:** instr 0x002081B3, rs1=5, rs2=7, out_ready=1 → next cycle a=5, b=7, code 0000, rd=3, reg_write=1. Then instr 0x402081B3 → code 1000.
- **SRAI:** instr 0x40315093 (SRAI x1,x2,3), rs1=0x80000000 → code 1101, b=3, reg_write=1, illegal=0.
- **Branches and upper-immediate ops:**
  - BLT (funct3 100) → code 0010, is_branch=1, reg_write=0, branch_funct3=100.
  - BGEU → code 0011.
  - AUIPC with pc=0x1000, U-imm 0x12345000 → a=0x1000, b=0x12345000.
- **Backpressure:** hold out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0. Release → held instruction consumed, the next one loaded on the same edge, no lost or duplicated instruction.
- **Flush:** out_valid=1 and in_valid=1 with flush=1 → out_valid=0 next cycle. The next accepted instruction decodes normally.
- **Illegal and reset:**
  - instr 0x00000000 → illegal=1, all control flags 0, out_valid=1.
  - Assert rst_n=0 mid-stall → out_valid=0 immediately and in_ready=1.
